// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: window placement in, sync/de/coords/window flags out.
// master = timing generator, slave = pixel fetch / colour mux consumer.
interface vga_timing_gen_if #(
  parameter int NUM_WIN = 2,
  parameter int CW      = 10
);
  logic [NUM_WIN*CW-1:0] win_x;
  logic [NUM_WIN*CW-1:0] win_y;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic [CW-1:0]         h_cnt;
  logic [CW-1:0]         v_cnt;
  logic                  line_start;
  logic                  frame_start;
  logic [NUM_WIN-1:0]    win_valid;
  logic [NUM_WIN*CW-1:0] win_px;
  logic [NUM_WIN*CW-1:0] win_py;

  modport master (
    input  win_x, win_y,
    output hsync, vsync, de, h_cnt, v_cnt,
    output line_start, frame_start,
    output win_valid, win_px, win_py
  );

  modport slave (
    output win_x, win_y,
    input  hsync, vsync, de, h_cnt, v_cnt,
    input  line_start, frame_start,
    input  win_valid, win_px, win_py
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with per-frame double-buffered windows.
// Ports: clk, rst (sync active-high), en (pixel tick), bus (vga_timing_gen_if.master).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int NUM_WIN   = 2,
  parameter int WIN_W     = 640,
  parameter int WIN_H     = 480,
  parameter int CW        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   WW     = (CW+1)'(WIN_W);
  localparam logic [CW:0]   WH     = (CW+1)'(WIN_H);

  logic [CW-1:0]         hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0]         sx_q [NUM_WIN];
  logic [CW-1:0]         sx_d [NUM_WIN];
  logic [CW-1:0]         sy_q [NUM_WIN];
  logic [CW-1:0]         sy_d [NUM_WIN];
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  de_q, de_d;
  logic [CW-1:0]         h_cnt_q, h_cnt_d;
  logic [CW-1:0]         v_cnt_q, v_cnt_d;
  logic                  ls_q, ls_d;
  logic                  fs_q, fs_d;
  logic [NUM_WIN-1:0]    wv_q, wv_d;
  logic [NUM_WIN*CW-1:0] px_q, px_d;
  logic [NUM_WIN*CW-1:0] py_q, py_d;

  logic          wrap_h, wrap_v, act;
  logic [CW:0]   h_ext, v_ext;
  logic [CW:0]   x_lo, y_lo;
  logic          in_w;

  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    wv_d    = wv_q;
    px_d    = px_q;
    py_d    = py_q;
    x_lo    = '0;
    y_lo    = '0;
    in_w    = 1'b0;

    wrap_h = (hc_q == H_LAST);
    wrap_v = (vc_q == V_LAST);
    act    = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
    // one extra bit so windows past the raster edge clip instead of wrapping
    h_ext  = {1'b0, hc_q};
    v_ext  = {1'b0, vc_q};

    if (en) begin
      hc_d = wrap_h ? '0 : hc_q + 1'b1;
      if (wrap_h)
        vc_d = wrap_v ? '0 : vc_q + 1'b1;

      hsync_d = (hc_q >= CW'(HS_BEG) && hc_q < CW'(HS_END))
              ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = (vc_q >= CW'(VS_BEG) && vc_q < CW'(VS_END))
              ? VSYNC_POL : ~VSYNC_POL;
      de_d    = act;
      h_cnt_d = hc_q;
      v_cnt_d = vc_q;
      ls_d    = (hc_q == '0);
      fs_d    = (hc_q == '0) && (vc_q == '0);

      for (int i = 0; i < NUM_WIN; i++) begin
        x_lo = {1'b0, sx_q[i]};
        y_lo = {1'b0, sy_q[i]};
        in_w = act
            && h_ext >= x_lo && h_ext < x_lo + WW
            && v_ext >= y_lo && v_ext < y_lo + WH;
        wv_d[i]         = in_w;
        px_d[i*CW +: CW] = in_w ? hc_q - sx_q[i] : '0;
        py_d[i*CW +: CW] = in_w ? vc_q - sy_q[i] : '0;
        // shadows swap on the last pixel so the new frame sees them from (0,0)
        if (wrap_h && wrap_v) begin
          sx_d[i] = bus.win_x[i*CW +: CW];
          sy_d[i] = bus.win_y[i*CW +: CW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      wv_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      wv_q    <= wv_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.h_cnt       = h_cnt_q;
  assign bus.v_cnt       = v_cnt_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.win_valid   = wv_q;
  assign bus.win_px      = px_q;
  assign bus.win_py      = py_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, two polarities, randomized en/windows.
// Reference model tracks a linear pixel index per frame and derives h/v arithmetically.
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NW = 2, CW = 5, WW = 5, WH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [NW*CW-1:0] win_x = '0;
  logic [NW*CW-1:0] win_y = '0;

  int checks = 0;
  int failures = 0;

  vga_timing_gen_if #(.NUM_WIN(NW), .CW(CW)) bus0 ();
  vga_timing_gen_if #(.NUM_WIN(NW), .CW(CW)) bus1 ();

  assign bus0.win_x = win_x;
  assign bus0.win_y = win_y;
  assign bus1.win_x = win_x;
  assign bus1.win_y = win_y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .NUM_WIN(NW), .WIN_W(WW), .WIN_H(WH), .CW(CW)
  ) dut0 (.clk(clk), .rst(rst), .en(en), .bus(bus0));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .NUM_WIN(NW), .WIN_W(WW), .WIN_H(WH), .CW(CW)
  ) dut1 (.clk(clk), .rst(rst), .en(en), .bus(bus1));

  always #5 clk = ~clk;

  // reference model state
  int p = 0;
  int sx [NW];
  int sy [NW];
  bit e_hin, e_vin, e_de, e_ls, e_fs;
  int e_h, e_v;
  bit e_wv [NW];
  int e_px [NW];
  int e_py [NW];

  task automatic model_reset();
    p = 0;
    e_hin = 0; e_vin = 0; e_de = 0; e_ls = 0; e_fs = 0;
    e_h = 0; e_v = 0;
    for (int i = 0; i < NW; i++) begin
      sx[i] = 0; sy[i] = 0;
      e_wv[i] = 0; e_px[i] = 0; e_py[i] = 0;
    end
  endtask

  task automatic model_pixel();
    int h, v;
    h = p % HT;
    v = p / HT;
    e_h   = h;
    e_v   = v;
    e_de  = (h < HA) && (v < VA);
    e_hin = (h >= HA + HFP) && (h < HA + HFP + HS);
    e_vin = (v >= VA + VFP) && (v < VA + VFP + VS);
    e_ls  = (h == 0);
    e_fs  = (p == 0);
    for (int i = 0; i < NW; i++) begin
      e_wv[i] = e_de && h >= sx[i] && h < sx[i] + WW
                     && v >= sy[i] && v < sy[i] + WH;
      e_px[i] = e_wv[i] ? h - sx[i] : 0;
      e_py[i] = e_wv[i] ? v - sy[i] : 0;
    end
    if (p == FRAME - 1)
      for (int i = 0; i < NW; i++) begin
        sx[i] = int'(win_x[i*CW +: CW]);
        sy[i] = int'(win_y[i*CW +: CW]);
      end
    p = (p + 1) % FRAME;
  endtask

  task automatic step(input bit e, input bit r);
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (e) model_pixel();
  endtask

  function automatic logic [38:0] exp_vec();
    logic [NW-1:0]    wv;
    logic [NW*CW-1:0] px, py;
    for (int i = 0; i < NW; i++) begin
      wv[i]          = e_wv[i];
      px[i*CW +: CW] = CW'(e_px[i]);
      py[i*CW +: CW] = CW'(e_py[i]);
    end
    return {~e_hin, ~e_vin, e_hin, e_vin, e_de,
            CW'(e_h), CW'(e_v), e_ls, e_fs, wv, px, py};
  endfunction

  function automatic logic [38:0] act_vec();
    return {bus0.hsync, bus0.vsync, bus1.hsync, bus1.vsync,
            bus0.de, bus0.h_cnt, bus0.v_cnt,
            bus0.line_start, bus0.frame_start,
            bus0.win_valid, bus0.win_px, bus0.win_py};
  endfunction

  task automatic set_win(input int i, input int x, input int y);
    win_x[i*CW +: CW] = CW'(x);
    win_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic test_reset();
    set_win(0, 3, 2);
    set_win(1, 14, 7);
    step(1'b0, 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_en0 got=%h want=%h", act_vec(), exp_vec());
    end
    step(1'b1, 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_en1 got=%h want=%h", act_vec(), exp_vec());
    end
    step(1'b0, 1'b0);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_first_tick();
    step(1'b1, 1'b0);
    checks++;
    if (bus0.frame_start !== 1'b1 || bus0.line_start !== 1'b1
        || bus0.de !== 1'b1 || bus0.h_cnt !== '0) begin
      failures++;
      $display("FAIL first_tick got fs=%b ls=%b de=%b h=%0d want 1 1 1 0",
               bus0.frame_start, bus0.line_start, bus0.de, bus0.h_cnt);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL first_tick_vec got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_full_frame();
    int n_fs, n_de, n_ls;
    n_fs = 0; n_de = 0; n_ls = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(1'b1, 1'b0);
      n_fs += int'(bus0.frame_start);
      n_de += int'(bus0.de);
      n_ls += int'(bus0.line_start);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL full_frame p=%0d got=%h want=%h", p, act_vec(), exp_vec());
      end
    end
    checks++;
    if (n_fs !== 2 || n_de !== 2 * HA * VA || n_ls !== 2 * VT) begin
      failures++;
      $display("FAIL frame_counts got fs=%0d de=%0d ls=%0d want 2 %0d %0d",
               n_fs, n_de, n_ls, 2 * HA * VA, 2 * VT);
    end
  endtask

  task automatic test_en_toggle();
    int n_fs, clks;
    n_fs = 0;
    clks = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(k[0] == 1'b0, 1'b0);
      clks++;
      n_fs += int'(bus0.frame_start && k[0] == 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_toggle k=%0d got=%h want=%h", k, act_vec(), exp_vec());
      end
    end
    checks++;
    if (n_fs !== 1) begin
      failures++;
      $display("FAIL en_toggle_period got=%0d want=1 frame per %0d clks", n_fs, clks);
    end
  endtask

  task automatic test_mid_frame_update();
    while (p != FRAME / 2) step(1'b1, 1'b0);
    set_win(0, 9, 4);
    for (int k = 0; k < FRAME + FRAME / 2; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL mid_update p=%0d got=%h want=%h", p, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ($urandom_range(0, 39) == 0)
        set_win($urandom_range(0, NW - 1),
                $urandom_range(0, 31), $urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random p=%0d got=%h want=%h", p, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2 * FRAME && p != HT * 5 + 7; k++)
      step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_mid got=%h want=%h", act_vec(), exp_vec());
    end
    step(1'b1, 1'b0);
    checks++;
    if (bus0.frame_start !== 1'b1 || bus0.h_cnt !== '0 || bus0.v_cnt !== '0) begin
      failures++;
      $display("FAIL reset_restart got fs=%b h=%0d v=%0d want 1 0 0",
               bus0.frame_start, bus0.h_cnt, bus0.v_cnt);
    end
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL after_reset p=%0d got=%h want=%h", p, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_full_frame();
    test_en_toggle();
    test_mid_frame_update();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path. It produces hsync, vsync and data-enable for any mode set by porch, sync and active parameters, with configurable sync polarity and a clock-enable input for the pixel rate. It also decodes NUM_WIN independently placed rectangular windows (playfield, HUD, overlays), giving per-window valid flags and window-local pixel coordinates. Window positions are double-buffered per frame so a moving window never tears. It sits between the pixel-clock domain and the per-layer pixel fetch/colour mux logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- NUM_WIN, 2, number of placement windows (1..8)
- WIN_W, 640, window width in pixels (common to all windows)
- WIN_H, 480, window height in lines
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel tick; all state advances only on cycles with en=1
- win_x  in  NUM_WIN*CW  window left edges, window i at bits [i*CW +: CW]
- win_y  in  NUM_WIN*CW  window top edges, same packing
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- de  out  1  active-video data enable
- h_cnt  out  CW  horizontal position of the current output pixel
- v_cnt  out  CW  vertical position of the current output pixel
- line_start  out  1  one-tick pulse, h_cnt==0
- frame_start  out  1  one-tick pulse, h_cnt==0 and v_cnt==0
- win_valid  out  NUM_WIN  pixel is inside window i and de=1
- win_px  out  NUM_WIN*CW  window-local x (h - win_x), 0 when not valid
- win_py  out  NUM_WIN*CW  window-local y (v - win_y), 0 when not valid

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch (same order vertically).
- Internal counters hc, vc: on en, hc increments; at H_TOTAL-1 it wraps to 0 and vc increments; vc wraps to 0 from V_TOTAL-1 while hc wraps.
- On every en tick the output registers load the decode of the current (hc, vc) while the counters advance.
- de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- hsync = HSYNC_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL. vsync is the same with V parameters on vc, independent of hc.
- Shadow registers sx[i], sy[i] load win_x/win_y on the en tick where (hc,vc) == (H_TOTAL-1, V_TOTAL-1). The window decode always uses the shadow values. Input changes mid-frame have no effect until the next frame.
- Window i is valid when de && sx[i] <= hc < sx[i]+WIN_W && sy[i] <= vc < sy[i]+WIN_H.
  - Sums are computed at CW+1 bits, so windows extending past the raster are clipped and never wrap.
- win_px/win_py are the CW-bit differences when valid, and 0 otherwise.
- On en=0 all registers hold, including outputs.

## Timing
- Reset (rst=1 on a clk edge, regardless of en): hc=vc=0, shadows=0.
  - Outputs: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, h_cnt=v_cnt=0, line_start=frame_start=0, win_valid=0, win_px=win_py=0.
- First en tick after reset: outputs show (0,0) with de=1 and frame_start=line_start=1. The counter moves to (1,0).
- Latency: outputs lag the counters by exactly one en tick. All outputs for one pixel are mutually consistent in the same cycle.
- Reset asserted mid-frame wins over en and returns to the reset state on that edge. The new frame starts at (0,0) on the next en tick.
- Frame period is H_TOTAL*V_TOTAL en ticks. Each frame has exactly one frame_start; each line has exactly one line_start.

## Test plan
- Default 640x480 with en=1: hsync low for output h_cnt 656..751, vsync low for lines 490..491, de high for 640x480 pixels per frame, and frame_start every 420000 cycles.
- en toggling 1/0: outputs hold on en=0 cycles. Frame period becomes 840000 clk cycles with identical sequences.
- HSYNC_POL=1, VSYNC_POL=1: sync pulses are high over the same ranges, and the idle level after reset is 0.
- NUM_WIN=2, WIN_W=32, WIN_H=16, win0=(100,50), win1=(620,470): win0 is valid for h 100..131 on lines 50..65, with win_px=0 at h=100. win1 is clipped to h 620..639 and lines 470..479 with no wrap.
- win_x changed mid-frame from 100 to 200 at line 240: the rest of that frame still uses 100, and the next frame uses 200 from line 0.
- rst pulsed at (h=300,v=200): outputs take reset values on that edge. The next en tick shows (0,0) with frame_start=1.
